sram_responder: RTL and testbench



---
 rtl/sram_if_pkg.sv | 31 +++
 rtl/sram_responder_if.sv | 36 +++
 rtl/sram_bank.sv | 38 +++
 rtl/sram_responder.sv | 213 +++++++++++++++++++++
 tb/tb_sram_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_if_pkg.sv
// ---------------------------------------------------------------------------
// sram_if_pkg
// Shared definitions for the SRAM-style RAM port responder:
//   - DATA_W            : width of the split data buses (16)
//   - RAM_READ_DELAY    : default read latency, same value as the global RAM_READ_DELAY
//   - RAM_WRITE_DELAY   : default write hold, same value as the global RAM_WRITE_DELAY
//   - state_t           : responder FSM states
//   - cnt_width()       : width of the wait-state counter for a given latency pair
// ---------------------------------------------------------------------------
package sram_if_pkg;

    localparam int DATA_W          = 16;
    localparam int RAM_READ_DELAY  = 4;
    localparam int RAM_WRITE_DELAY = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_DONE
    } state_t;

    // Counter must be able to hold max(read_lat, write_min) - 1 without overflow.
    function automatic int cnt_width(input int read_lat, input int write_min);
        int m;
        m = (read_lat > write_min) ? read_lat : write_min;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
// SRAM-style RAM port: active-low chip/output/write enables, word address and
// split 16-bit data buses.
//   ram_a     word address            (master -> slave)
//   ram_dq_i  write data              (master -> slave)
//   ram_dq_o  read data               (slave -> master)
//   ram_cen   chip enable, active low (master -> slave)
//   ram_oen   output enable, active low
//   ram_wen   write enable, active low
// Modports: master (initiator, e.g. the sample request arbiter), slave (responder).
// ---------------------------------------------------------------------------
interface sram_responder_if
    import sram_if_pkg::*;
#(
    parameter int ADDR_W = 27
);

    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_dq_i;
    logic [DATA_W-1:0] ram_dq_o;
    logic              ram_cen;
    logic              ram_oen;
    logic              ram_wen;

    modport master (
        output ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen,
        input  ram_dq_o
    );

    modport slave (
        input  ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen,
        output ram_dq_o
    );

endinterface

// File: rtl/sram_bank.sv
// ---------------------------------------------------------------------------
// sram_bank
// Single-port synchronous block RAM, DATA_W x 2^DEPTH_LOG2 words, one-cycle
// registered read. A write takes priority over a read in the same cycle and
// does not update rdata.
//   clk    system clock
//   rd_en  load rdata from mem[addr] at the next edge
//   wr_en  write wdata to mem[addr] at the next edge
//   addr   word index
//   wdata  write data
//   rdata  registered read data (holds between reads)
// ---------------------------------------------------------------------------
module sram_bank
    import sram_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset branch; a reset on every word would stop the
    // tools mapping it onto block RAM, and contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Target end of the SRAM-style RAM port, backed by on-chip block RAM. Accesses
// are decoded from the strobes in IDLE, held for fixed wait states, then
// committed (write) or returned on ram_dq_o (read).
//   clk           system clock
//   reset         synchronous, active-high
//   bus           sram_responder_if.slave (ram_a, ram_dq_i, ram_dq_o, enables)
//   busy          high (one cycle delayed) while the FSM is outside IDLE
//   oob           one-cycle pulse, one cycle after acceptance, when address
//                 bits at or above DEPTH_LOG2 are set (access uses wrapped index)
//   wr_commits    committed write count, wraps 0xFFFF -> 0
//   protocol_err  sticky initiator-violation flag
// Parameters: READ_LAT >= 2, WRITE_MIN >= 1.
// Optional build macro SRAM_PROTOCOL_CHECK_EN: enables the protocol checker
// driving protocol_err; without it protocol_err is tied low.
// ---------------------------------------------------------------------------
module sram_responder
    import sram_if_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int DEPTH_LOG2 = 16,
    parameter int READ_LAT   = RAM_READ_DELAY,
    parameter int WRITE_MIN  = RAM_WRITE_DELAY
) (
    input  logic               clk,
    input  logic               reset,
    sram_responder_if.slave    bus,
    output logic               busy,
    output logic               oob,
    output logic [15:0]        wr_commits,
    output logic               protocol_err
);

    localparam int CNT_W = cnt_width(READ_LAT, WRITE_MIN);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       dq_q;
    logic                    armed;     // cen seen high since the last accepted access
    logic                    oob_pend;
    logic                    oob_q;
    logic                    busy_q;
    logic [15:0]             commit_cnt;

    logic                    rd_req;
    logic                    wr_req;
    logic                    accept;
    logic                    upper_set;
    logic                    commit;
    logic [DEPTH_LOG2-1:0]   bank_addr;
    logic                    bank_rd;
    logic [DATA_W-1:0]       bank_rdata;

    // NOTE: every signal gets a default before any condition so no latch can form.
    always_comb begin
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        bank_rd   = 1'b0;
        bank_addr = idx_q;
        upper_set = |bus.ram_a[ADDR_W-1:DEPTH_LOG2];

        rd_req = !bus.ram_cen && !bus.ram_oen &&  bus.ram_wen;
        wr_req = !bus.ram_cen &&  bus.ram_oen && !bus.ram_wen;

        if (state == IDLE) begin
            // The bank samples the live address at T, so read data is ready
            // long before the wait count expires.
            bank_addr = bus.ram_a[DEPTH_LOG2-1:0];
            accept    = armed && (rd_req || wr_req);
            bank_rd   = accept && rd_req;
        end

        commit = (state == WR_WAIT) && !bus.ram_cen && !bus.ram_wen &&
                 (cnt == CNT_W'(WRITE_MIN - 1));
    end

    sram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .rd_en (bank_rd),
        .wr_en (commit),
        .addr  (bank_addr),
        .wdata (wdata_q),
        .rdata (bank_rdata)
    );

    // NOTE: non-blocking assignments throughout so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            dq_q       <= '0;
            armed      <= 1'b1;
            oob_pend   <= 1'b0;
            oob_q      <= 1'b0;
            busy_q     <= 1'b0;
            commit_cnt <= '0;
        end else begin
            oob_pend <= accept && upper_set;
            oob_q    <= oob_pend;
            busy_q   <= (state != IDLE);

            if (bus.ram_cen) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q <= bus.ram_a[DEPTH_LOG2-1:0];
                        cnt   <= '0;
                        armed <= 1'b0;
                        if (rd_req) begin
                            state <= RD_WAIT;
                        end else begin
                            wdata_q <= bus.ram_dq_i;
                            state   <= WR_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (bus.ram_cen || bus.ram_oen) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(READ_LAT - 1)) begin
                        dq_q  <= bank_rdata;
                        state <= RD_DRIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RD_DRIVE: begin
                    if (bus.ram_cen) begin
                        dq_q  <= '0;
                        state <= IDLE;
                    end
                end

                WR_WAIT: begin
                    if (bus.ram_cen || bus.ram_wen) begin
                        state <= IDLE;
                    end else if (commit) begin
                        commit_cnt <= commit_cnt + 1'b1;
                        state      <= WR_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WR_DONE: begin
                    if (bus.ram_cen) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ram_dq_o = dq_q;
    assign busy         = busy_q;
    assign oob          = oob_q;
    assign wr_commits   = commit_cnt;

`ifdef SRAM_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              illegal;
    logic              addr_chg;
    logic              data_chg;
    logic              abort;

    always_comb begin
        illegal  = !bus.ram_cen && !bus.ram_oen && !bus.ram_wen;
        // Only flag changes while the initiator still owns the access (cen low).
        addr_chg = (state != IDLE) && !bus.ram_cen && (bus.ram_a != addr_q);
        data_chg = (state == WR_WAIT) && !bus.ram_cen && !bus.ram_wen &&
                   (bus.ram_dq_i != wdata_q);
        abort    = ((state == RD_WAIT) && (bus.ram_cen || bus.ram_oen)) ||
                   ((state == WR_WAIT) && (bus.ram_cen || bus.ram_wen));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= bus.ram_a;
            end
            if (illegal || addr_chg || data_chg || abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
// Directed bench for sram_responder: a table of single accesses with
// hand-computed results, followed by hand-written multi-cycle sequences
// (read latency edges, address change after T, strobe re-entry, reset in
// RD_WAIT, illegal strobes, write counter wrap).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_responder;
    import sram_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        oob;
    logic [15:0] wr_commits;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    sram_responder_if #(.ADDR_W(27)) bus_if ();

    sram_responder #(
        .ADDR_W     (27),
        .DEPTH_LOG2 (16),
        .READ_LAT   (4),
        .WRITE_MIN  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .busy         (busy),
        .oob          (oob),
        .wr_commits   (wr_commits),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

`ifdef SRAM_PROTOCOL_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    typedef struct {
        logic        is_wr;
        logic [26:0] addr;
        logic [15:0] data;
        int          hold;
        logic [15:0] exp_data;
        logic [15:0] exp_commits;
        logic        exp_oob;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_bus();
        bus_if.ram_cen = 1'b1;
        bus_if.ram_oen = 1'b1;
        bus_if.ram_wen = 1'b1;
    endtask

    // One complete access: strobes low for 'hold' edges (T .. T+hold-1), then
    // released for two edges so busy has dropped by the end.
    task automatic do_access(input logic is_wr, input logic [26:0] a, input logic [15:0] d,
                             input int hold, output logic oob1, output logic oob2,
                             output logic [15:0] rd_last, output logic [15:0] rd_after,
                             output logic busy_end);
        bus_if.ram_a    = a;
        bus_if.ram_dq_i = d;
        bus_if.ram_oen  = is_wr;
        bus_if.ram_wen  = !is_wr;
        bus_if.ram_cen  = 1'b0;
        oob1     = 1'b0;
        oob2     = 1'b0;
        rd_last  = '0;
        rd_after = '0;
        for (int k = 0; k < hold + 2; k++) begin
            if (k == hold) idle_bus();
            tick();
            if (k == 1)        oob1     = oob;
            if (k == 2)        oob2     = oob;
            if (k == hold - 1) rd_last  = bus_if.ram_dq_o;
            if (k == hold)     rd_after = bus_if.ram_dq_o;
        end
        busy_end = busy;
    endtask

    initial begin
        logic        o1, o2, bz;
        logic [15:0] rl, ra;

        vecs[0] = '{1'b1, 27'h0000005, 16'h1234, 3, 16'h0000, 16'd1, 1'b0};
        vecs[1] = '{1'b0, 27'h0000005, 16'h0000, 6, 16'h1234, 16'd1, 1'b0};
        vecs[2] = '{1'b1, 27'h0000007, 16'hBEEF, 3, 16'h0000, 16'd2, 1'b0};
        vecs[3] = '{1'b1, 27'h0000007, 16'hDEAD, 1, 16'h0000, 16'd2, 1'b0};
        vecs[4] = '{1'b0, 27'h0000007, 16'h0000, 6, 16'hBEEF, 16'd2, 1'b0};
        vecs[5] = '{1'b0, 27'h0010005, 16'h0000, 6, 16'h1234, 16'd2, 1'b1};
        vecs[6] = '{1'b1, 27'h002FFFF, 16'hA5A5, 3, 16'h0000, 16'd3, 1'b1};
        vecs[7] = '{1'b0, 27'h000FFFF, 16'h0000, 6, 16'hA5A5, 16'd3, 1'b0};
        vecs[8] = '{1'b1, 27'h0000000, 16'h0001, 4, 16'h0000, 16'd4, 1'b0};
        vecs[9] = '{1'b0, 27'h0000000, 16'h0000, 5, 16'h0001, 16'd4, 1'b0};

        idle_bus();
        bus_if.ram_a    = '0;
        bus_if.ram_dq_i = '0;
        reset = 1'b1;
        tick();
        tick();
        check("reset_dq",    32'(bus_if.ram_dq_o), 32'h0);
        check("reset_busy",  32'(busy),            32'h0);
        check("reset_oob",   32'(oob),             32'h0);
        check("reset_wrc",   32'(wr_commits),      32'h0);
        check("reset_perr",  32'(protocol_err),    32'h0);
        reset = 1'b0;
        tick();

        // Table-driven single accesses.
        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].hold, o1, o2, rl, ra, bz);
            check($sformatf("vec%0d_oob", i),      32'(o1),         32'(vecs[i].exp_oob));
            check($sformatf("vec%0d_oob_end", i),  32'(o2),         32'h0);
            check($sformatf("vec%0d_commits", i),  32'(wr_commits), 32'(vecs[i].exp_commits));
            check($sformatf("vec%0d_busy_end", i), 32'(bz),         32'h0);
            check($sformatf("vec%0d_dq_after", i), 32'(ra),         32'h0);
            if (!vecs[i].is_wr) begin
                check($sformatf("vec%0d_rdata", i), 32'(rl), 32'(vecs[i].exp_data));
            end
        end

        // Read latency edges on addr 5.
        bus_if.ram_a   = 27'h5;
        bus_if.ram_cen = 1'b0;
        bus_if.ram_oen = 1'b0;
        tick();                                   // edge T
        check("rd_busy_T",   32'(busy), 32'h0);
        tick();                                   // T+1
        check("rd_busy_T1",  32'(busy), 32'h1);
        tick();                                   // T+2
        tick();                                   // T+3
        check("rd_dq_T3",    32'(bus_if.ram_dq_o), 32'h0);
        tick();                                   // T+4
        check("rd_dq_T4",    32'(bus_if.ram_dq_o), 32'h1234);
        tick();                                   // T+5
        check("rd_dq_T5",    32'(bus_if.ram_dq_o), 32'h1234);
        idle_bus();
        tick();                                   // cen sampled high
        check("rd_dq_release",   32'(bus_if.ram_dq_o), 32'h0);
        check("rd_busy_release", 32'(busy),            32'h1);
        tick();
        check("rd_busy_fall",    32'(busy),            32'h0);

        // Address changed after T is ignored.
        bus_if.ram_a   = 27'h7;
        bus_if.ram_cen = 1'b0;
        bus_if.ram_oen = 1'b0;
        tick();
        bus_if.ram_a = 27'h5;
        for (int k = 0; k < 5; k++) tick();
        check("addr_latched", 32'(bus_if.ram_dq_o), 32'hBEEF);
        idle_bus();
        tick();
        tick();

        // Abort by oen with cen held low, then oen low again: no new access.
        bus_if.ram_a   = 27'h5;
        bus_if.ram_cen = 1'b0;
        bus_if.ram_oen = 1'b0;
        tick();
        tick();
        bus_if.ram_oen = 1'b1;
        tick();                                   // abort edge
        bus_if.ram_oen = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("reentry_busy", 32'(busy),            32'h0);
        check("reentry_dq",   32'(bus_if.ram_dq_o), 32'h0);
        idle_bus();
        tick();
        tick();

        // Reset while in RD_WAIT with cnt==2.
        bus_if.ram_a   = 27'h5;
        bus_if.ram_cen = 1'b0;
        bus_if.ram_oen = 1'b0;
        tick();                                   // T
        tick();                                   // T+1
        tick();                                   // T+2, cnt now 2
        reset = 1'b1;
        tick();
        check("rst_mid_busy", 32'(busy),            32'h0);
        check("rst_mid_dq",   32'(bus_if.ram_dq_o), 32'h0);
        check("rst_mid_wrc",  32'(wr_commits),      32'h0);
        reset = 1'b0;
        idle_bus();
        tick();
        do_access(1'b0, 27'h5, 16'h0, 6, o1, o2, rl, ra, bz);
        check("rst_keep_a5", 32'(rl), 32'h1234);
        do_access(1'b0, 27'hFFFF, 16'h0, 6, o1, o2, rl, ra, bz);
        check("rst_keep_affff", 32'(rl), 32'hA5A5);
        check("rst_perr_clear", 32'(protocol_err), 32'h0);

        // Illegal: all three strobes low.
        bus_if.ram_cen = 1'b0;
        bus_if.ram_oen = 1'b0;
        bus_if.ram_wen = 1'b0;
        tick();
        tick();
        check("illegal_busy1", 32'(busy), 32'h0);
        tick();
        check("illegal_busy2", 32'(busy), 32'h0);
        idle_bus();
        tick();
        check("illegal_busy3", 32'(busy),         32'h0);
        check("illegal_wrc",   32'(wr_commits),   32'h0);
        check("illegal_perr",  32'(protocol_err), 32'(EXP_PERR));

        // Write counter wrap (counter preloaded to 0xFFFE).
        force dut.commit_cnt = 16'hFFFE;
        tick();
        release dut.commit_cnt;
        tick();
        check("wrap_preload", 32'(wr_commits), 32'hFFFE);
        do_access(1'b1, 27'h9, 16'h5A5A, 3, o1, o2, rl, ra, bz);
        check("wrap_ffff", 32'(wr_commits), 32'hFFFF);
        do_access(1'b1, 27'h9, 16'h6B6B, 3, o1, o2, rl, ra, bz);
        check("wrap_zero", 32'(wr_commits), 32'h0);
        do_access(1'b0, 27'h9, 16'h0, 6, o1, o2, rl, ra, bz);
        check("wrap_rdata", 32'(rl), 32'h6B6B);
        check("final_perr", 32'(protocol_err), 32'(EXP_PERR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
